// File: rtl/four_input_rr_arbiter.sv
// rtl/four_input_rr_arbiter.sv - four-requester round-robin arbiter with break-before-make gap
//
// Purpose: shares one downstream resource between requesters A..D (req[0..3]).
//   IDLE arbitrates round-robin from ptr, GRANT holds the owner until it drops
//   req, and GAP inserts one dead cycle before the next arbitration.
// Optional feature macro: ARB_TIMEOUT_EN (hold watchdog with per-requester mask).
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   req      in   [3:0] level request lines, held while owner
//   gnt      out  [3:0] registered one-hot grant
//   owner    out  [1:0] index of current/last owner
//   busy     out  high while any gnt bit is high
//   any_req  out  combinational OR of req
//   hold_cnt out  [CNT_W-1:0] cycles the current owner has held the grant
//   timeout  out  one-cycle pulse on forced release (0 without the feature)

module four_input_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    output logic [1:0]       owner,
    output logic             busy,
    output logic             any_req,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             timeout
);

    // Elaboration-time sanity check of the parameter set.
    if (MAX_HOLD < 2 || MAX_HOLD > 255 || (64'(1) << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_param
        $error("four_input_rr_arbiter: illegal MAX_HOLD/CNT_W combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       mask;

    logic [3:0]       elig;
    logic [1:0]       pick;
    logic             pick_vld;
    logic [1:0]       scan_idx;
    logic             owner_req;
    logic             hold_expired;

`ifdef ARB_TIMEOUT_EN
    logic [3:0] mask_q, mask_d;
    assign mask         = mask_q;
    assign hold_expired = (hold_cnt_q == CNT_W'(MAX_HOLD));
`else
    assign mask         = 4'b0000;
    assign hold_expired = 1'b0;
`endif

    assign any_req   = |req;
    assign elig      = req & ~mask;
    assign owner_req = req[owner_q];

    // First eligible requester scanning upward from ptr, wrapping modulo 4.
    always_comb begin
        pick     = 2'd0;
        pick_vld = 1'b0;
        scan_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = ptr_q + 2'(i);
            if (!pick_vld && elig[scan_idx]) begin
                pick     = scan_idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        // A requester's mask bit lifts once it has let go of req.
        mask_d     = mask_q & req;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d      = 4'b0001 << pick;
                    owner_d    = pick;
                    hold_cnt_d = CNT_W'(1);
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!owner_req || hold_expired) begin
                    gnt_d      = 4'b0000;
                    hold_cnt_d = '0;
                    ptr_d      = owner_q + 2'd1;
                    state_d    = ST_GAP;
`ifdef ARB_TIMEOUT_EN
                    if (owner_req) begin
                        timeout_d       = 1'b1;
                        mask_d[owner_q] = 1'b1;
                    end
`endif
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 4'b0000;
            owner_q    <= 2'd0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            mask_q     <= 4'b0000;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`ifdef ARB_TIMEOUT_EN
            mask_q     <= mask_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign busy     = |gnt_q;
    assign hold_cnt = hold_cnt_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_four_input_rr_arbiter.sv
// tb/tb_four_input_rr_arbiter.sv - directed vector bench for four_input_rr_arbiter

module tb_four_input_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       any_req;
    logic [7:0] hold_cnt;
    logic       timeout;

    int n_total = 0;
    int n_pass  = 0;

    four_input_rr_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .owner    (owner),
        .busy     (busy),
        .any_req  (any_req),
        .hold_cnt (hold_cnt),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic [7:0] hold;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] o,
                       input logic [7:0] h, input logic t);
        vec_t v;
        v.req = r; v.gnt = g; v.owner = o; v.hold = h; v.to = t;
        tbl.push_back(v);
    endtask

    // Each vector: drive req, take one rising edge, check outputs 1 time unit later.
    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            req = tbl[i].req;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d].gnt", tag, i), 32'(gnt), 32'(tbl[i].gnt));
            check($sformatf("%s[%0d].owner", tag, i), 32'(owner), 32'(tbl[i].owner));
            check($sformatf("%s[%0d].hold", tag, i), 32'(hold_cnt), 32'(tbl[i].hold));
            check($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(|tbl[i].gnt));
            check($sformatf("%s[%0d].timeout", tag, i), 32'(timeout), 32'(tbl[i].to));
            check($sformatf("%s[%0d].any_req", tag, i), 32'(any_req), 32'(|tbl[i].req));
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        req = 4'b0000;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("reset.gnt", 32'(gnt), 32'h0);
        check("reset.owner", 32'(owner), 32'h0);
        check("reset.busy", 32'(busy), 32'h0);
        check("reset.hold", 32'(hold_cnt), 32'h0);
        check("reset.timeout", 32'(timeout), 32'h0);

        // Single requester C from edge 5 to edge 10, then skip-and-wrap from ptr=3.
        for (int i = 0; i < 4; i++) add(4'b0000, 4'b0000, 2'd0, 8'd0, 1'b0);
        add(4'b0100, 4'b0100, 2'd2, 8'd1, 1'b0);
        for (int i = 2; i <= 5; i++) add(4'b0100, 4'b0100, 2'd2, 8'(i), 1'b0);
        add(4'b0000, 4'b0000, 2'd2, 8'd0, 1'b0);   // release -> GAP
        add(4'b0000, 4'b0000, 2'd2, 8'd0, 1'b0);   // GAP -> IDLE
        add(4'b0011, 4'b0001, 2'd0, 8'd1, 1'b0);   // ptr=3: D absent, wraps to A
        add(4'b0010, 4'b0000, 2'd0, 8'd0, 1'b0);
        add(4'b0010, 4'b0000, 2'd0, 8'd0, 1'b0);
        add(4'b0010, 4'b0010, 2'd1, 8'd1, 1'b0);
        add(4'b0000, 4'b0000, 2'd1, 8'd0, 1'b0);
        add(4'b0000, 4'b0000, 2'd1, 8'd0, 1'b0);
        run_table("single_wrap");

        // Round-robin rotation: everybody requests, owner drops for one cycle.
        do_reset();
        add(4'b1111, 4'b0001, 2'd0, 8'd1, 1'b0);
        add(4'b1110, 4'b0000, 2'd0, 8'd0, 1'b0);
        add(4'b1111, 4'b0000, 2'd0, 8'd0, 1'b0);
        add(4'b1111, 4'b0010, 2'd1, 8'd1, 1'b0);
        add(4'b1101, 4'b0000, 2'd1, 8'd0, 1'b0);
        add(4'b1111, 4'b0000, 2'd1, 8'd0, 1'b0);
        add(4'b1111, 4'b0100, 2'd2, 8'd1, 1'b0);
        add(4'b1011, 4'b0000, 2'd2, 8'd0, 1'b0);
        add(4'b1111, 4'b0000, 2'd2, 8'd0, 1'b0);
        add(4'b1111, 4'b1000, 2'd3, 8'd1, 1'b0);
        add(4'b0111, 4'b0000, 2'd3, 8'd0, 1'b0);
        add(4'b1111, 4'b0000, 2'd3, 8'd0, 1'b0);
        add(4'b1111, 4'b0001, 2'd0, 8'd1, 1'b0);
        run_table("rotate");

        // No preemption: A keeps the grant while all four request.
        for (int i = 0; i < 20; i++) begin
            req = 4'b1111;
            @(posedge clk);
            #1;
            check($sformatf("nopre[%0d].gnt", i), 32'(gnt), 32'h1);
            check($sformatf("nopre[%0d].any_req", i), 32'(any_req), 32'h1);
            check($sformatf("nopre[%0d].hold", i), 32'(hold_cnt), 32'(i + 2));
        end

        // A releases (ptr=1), only C requests -> C granted after the gap.
        add(4'b0100, 4'b0000, 2'd0, 8'd0, 1'b0);
        add(4'b0100, 4'b0000, 2'd0, 8'd0, 1'b0);
        add(4'b0100, 4'b0100, 2'd2, 8'd1, 1'b0);
        run_table("to_c");

        // Asynchronous reset mid-grant, checked before the next clock edge.
        #3;
        rst = 1'b1;
        #1;
        check("async_rst.gnt", 32'(gnt), 32'h0);
        check("async_rst.busy", 32'(busy), 32'h0);
        check("async_rst.owner", 32'(owner), 32'h0);
        check("async_rst.hold", 32'(hold_cnt), 32'h0);
        check("async_rst.any_req", 32'(any_req), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b1111;
        @(posedge clk);
        #1;
        check("post_rst.gnt", 32'(gnt), 32'h1);
        check("post_rst.owner", 32'(owner), 32'h0);

`ifdef ARB_TIMEOUT_EN
        // Stuck A is forced off at hold 16, D served next, A masked until it drops req.
        do_reset();
        add(4'b1001, 4'b0001, 2'd0, 8'd1, 1'b0);
        for (int i = 2; i <= 16; i++) add(4'b1001, 4'b0001, 2'd0, 8'(i), 1'b0);
        add(4'b1001, 4'b0000, 2'd0, 8'd0, 1'b1);
        add(4'b1001, 4'b0000, 2'd0, 8'd0, 1'b0);
        add(4'b1001, 4'b1000, 2'd3, 8'd1, 1'b0);
        add(4'b0001, 4'b0000, 2'd3, 8'd0, 1'b0);
        add(4'b0001, 4'b0000, 2'd3, 8'd0, 1'b0);
        add(4'b0001, 4'b0000, 2'd3, 8'd0, 1'b0);
        add(4'b0000, 4'b0000, 2'd3, 8'd0, 1'b0);
        add(4'b0001, 4'b0001, 2'd0, 8'd1, 1'b0);
        run_table("timeout");
`else
        // Without the watchdog a long hold runs past 16 with no timeout pulse.
        do_reset();
        add(4'b1001, 4'b0001, 2'd0, 8'd1, 1'b0);
        for (int i = 2; i <= 18; i++) add(4'b1001, 4'b0001, 2'd0, 8'(i), 1'b0);
        run_table("no_watchdog");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/four_input_rr_arbiter.md
Name: four_input_rr_arbiter

Overview:
- Round-robin arbiter that shares a single downstream resource between four requesters A, B, C and D.
- It is the sequencing counterpart of the four-input OR datapath:
  - `any_req` is the OR of the four requests.
  - The registered one-hot grant selects which requester owns the resource.
- Requesters hold `req` for as long as they need the resource and drop it to release.
- A hold counter tracks ownership length and drives an optional watchdog.

Parameters:
- MAX_HOLD, 16: maximum grant length in cycles before a forced release (used only when the timeout feature is compiled in); legal range 2..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous active-high reset.
- req  in  4  request lines; bit0=A, bit1=B, bit2=C, bit3=D; level-sensitive, held while owner.
- gnt  out  4  registered one-hot grant; all-zero when nobody owns the resource.
- owner  out  2  index of the current/last owner (0..3).
- busy  out  1  high while any gnt bit is high.
- any_req  out  1  combinational OR of req[3:0].
- hold_cnt  out  CNT_W  cycles the current owner has held the grant; 0 when idle.
- timeout  out  1  one-cycle pulse on forced release (constant 0 without feature).

Behaviour:
- Async reset, applied immediately and held while rst=1:
  - state=IDLE, gnt=0, owner=0, busy=0, hold_cnt=0, timeout=0.
  - Round-robin pointer ptr=0.
  - Timeout mask=0.
- FSM states: IDLE, GRANT, GAP. All transitions occur on the rising edge of clk.
- IDLE:
  - Computes the eligible set: req & ~mask.
  - Scans from ptr upward, modulo 4, and picks the first eligible bit.
  - If the eligible set is non-zero: on the next edge gnt=onehot(pick), owner=pick, hold_cnt=1, busy=1, state=GRANT.
  - Otherwise it stays in IDLE.
  - Latency: req sampled high at edge k gives gnt high after edge k (visible during cycle k..k+1). No combinational path from req to gnt.
- GRANT:
  - While req[owner]=1, gnt is held and hold_cnt increments, saturating at 2^CNT_W-1.
  - When req[owner]=0 at an edge: gnt=0, busy=0, hold_cnt=0, ptr=owner+1 (mod 4), state=GAP.
  - Requests from other requesters are ignored during GRANT, so there is no preemption.
- GAP:
  - Exactly one dead cycle with gnt=0, which guarantees break-before-make between owners.
  - Next state is IDLE unconditionally.
  - Minimum turnaround is therefore 2 edges from release to the next grant.
- owner keeps the last granted index after release; only reset clears it.
- Fairness: with all four requesting continuously and each releasing after one cycle, the grant order is A,B,C,D,A,...
- Simultaneous events:
  - The owner dropping req while others raise theirs follows the normal path: GAP, then IDLE arbitration from the new ptr.
  - A request that rises and falls while the arbiter is in GRANT or GAP is lost; requesters must hold req until granted.
- rst asserted mid-GRANT: gnt drops asynchronously and all state returns to reset values. ptr=0 after reset, so A has first priority.
- any_req is purely combinational and valid even during reset.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, if hold_cnt==MAX_HOLD and req[owner] is still 1, the next edge forces a release: gnt=0, busy=0, hold_cnt=0, timeout=1 for one cycle, ptr=owner+1, mask[owner]=1, state=GAP.
  - mask[i] clears on any edge where req[i]=0.
  - A masked requester is ineligible in IDLE, so a stuck requester cannot starve the others.
- Not defined: there is no watchdog, and timeout is tied to 0. The mask register is absent and treated as 0. Grants last indefinitely while req is held.

Test Plan:
- Reset check: assert rst mid-run with gnt=4'b0100 -> gnt=0, busy=0, owner=0 and hold_cnt=0 immediately (before the next clk edge); after release, req=4'b1111 -> first gnt=4'b0001.
- Single requester: raise req=4'b0100 at edge 5, drop it at edge 10 -> gnt=4'b0100 after edge 5, hold_cnt reaches 5, gnt=0 after edge 10, one GAP cycle follows, then IDLE.
- Round-robin rotation: req=4'b1111, each owner drops its req for one cycle after grant -> grant sequence 0001,0010,0100,1000,0001 with gnt=0 for exactly 2 edges between grants.
- Skip and wrap: ptr=3 (after a C release), req=4'b0011 -> next gnt=4'b0001 (A), then after release 4'b0010 (B).
- No preemption: A granted, then req=4'b1111 for 20 cycles with A held -> gnt stays 4'b0001 throughout, and any_req=1.
- With ARB_TIMEOUT_EN and MAX_HOLD=16: req=4'b1001 held constantly -> A released after hold_cnt=16 with a 1-cycle timeout pulse, then D granted; A is not re-granted until it drops req for one or more cycles.
